// File: rtl/e_pipe_ctrl_if.sv
// rtl/e_pipe_ctrl_if.sv - decode-to-execute field bundle: D/d fields in, E register fields out
interface e_pipe_ctrl_if #(
    parameter int DATA_W = 64,
    parameter int REG_W  = 4,
    parameter int STAT_W = 3
);
    logic [STAT_W-1:0] D_stat;
    logic [3:0]        D_icode;
    logic [3:0]        D_ifun;
    logic [DATA_W-1:0] D_valC;
    logic [DATA_W-1:0] d_valA;
    logic [DATA_W-1:0] d_valB;
    logic [REG_W-1:0]  d_dstE;
    logic [REG_W-1:0]  d_dstM;
    logic [REG_W-1:0]  d_srcA;
    logic [REG_W-1:0]  d_srcB;

    logic [STAT_W-1:0] E_stat;
    logic [3:0]        E_icode;
    logic [3:0]        E_ifun;
    logic [DATA_W-1:0] E_valC;
    logic [DATA_W-1:0] E_valA;
    logic [DATA_W-1:0] E_valB;
    logic [REG_W-1:0]  E_dstE;
    logic [REG_W-1:0]  E_dstM;
    logic [REG_W-1:0]  E_srcA;
    logic [REG_W-1:0]  E_srcB;

    modport master (
        output D_stat, D_icode, D_ifun, D_valC, d_valA, d_valB,
               d_dstE, d_dstM, d_srcA, d_srcB,
        input  E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
               E_dstE, E_dstM, E_srcA, E_srcB
    );

    modport slave (
        input  D_stat, D_icode, D_ifun, D_valC, d_valA, d_valB,
               d_dstE, d_dstM, d_srcA, d_srcB,
        output E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
               E_dstE, E_dstM, E_srcA, E_srcB
    );
endinterface

// File: rtl/e_pipe_ctrl.sv
// rtl/e_pipe_ctrl.sv - Y86-64 E pipeline register with load/use, mispredict, ret and exception control
module e_pipe_ctrl #(
    parameter int DATA_W = 64,
    parameter int REG_W  = 4,
    parameter int STAT_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    e_pipe_ctrl_if.slave      de_if,
    input  logic [3:0]        M_icode_i,
    input  logic              e_Cnd_i,
    input  logic [STAT_W-1:0] m_stat_i,
    input  logic [STAT_W-1:0] W_stat_i,
    output logic              F_stall_o,
    output logic              D_stall_o,
    output logic              D_bubble_o,
    output logic              M_bubble_o,
    output logic              W_stall_o,
    output logic              set_cc_o
);
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [STAT_W-1:0] S_AOK = STAT_W'(1);
    localparam logic [STAT_W-1:0] S_HLT = STAT_W'(2);
    localparam logic [STAT_W-1:0] S_ADR = STAT_W'(3);
    localparam logic [STAT_W-1:0] S_INS = STAT_W'(4);

    localparam logic [REG_W-1:0] RNONE = {REG_W{1'b1}};

    typedef struct packed {
        logic [STAT_W-1:0] stat;
        logic [3:0]        icode;
        logic [3:0]        ifun;
        logic [DATA_W-1:0] valc;
        logic [DATA_W-1:0] vala;
        logic [DATA_W-1:0] valb;
        logic [REG_W-1:0]  dste;
        logic [REG_W-1:0]  dstm;
        logic [REG_W-1:0]  srca;
        logic [REG_W-1:0]  srcb;
    } e_reg_t;

    localparam e_reg_t E_BUBBLE = '{
        stat:  S_AOK,
        icode: I_NOP,
        ifun:  4'h0,
        valc:  '0,
        vala:  '0,
        valb:  '0,
        dste:  RNONE,
        dstm:  RNONE,
        srca:  RNONE,
        srcb:  RNONE
    };

    function automatic logic exc(input logic [STAT_W-1:0] s);
        return (s == S_ADR) || (s == S_INS) || (s == S_HLT);
    endfunction

    e_reg_t e_q;
    e_reg_t e_d;

    logic load_use;
    logic mispredict;
    logic ret_in_pipe;
    logic e_bubble;
    logic m_exc;
    logic w_exc;

    // A load with no destination (dstM == RNONE) must not match RNONE source fields.
    always_comb begin
        load_use    = ((e_q.icode == I_MRMOVQ) || (e_q.icode == I_POPQ)) &&
                      (e_q.dstm != RNONE) &&
                      ((e_q.dstm == de_if.d_srcA) || (e_q.dstm == de_if.d_srcB));
        mispredict  = (e_q.icode == I_JXX) && !e_Cnd_i;
        ret_in_pipe = (de_if.D_icode == I_RET) || (e_q.icode == I_RET) ||
                      (M_icode_i == I_RET);
        m_exc       = exc(m_stat_i);
        w_exc       = exc(W_stat_i);
        e_bubble    = mispredict || load_use;
    end

    assign F_stall_o  = load_use || ret_in_pipe;
    assign D_stall_o  = load_use;
    assign D_bubble_o = mispredict || (!load_use && ret_in_pipe);
    assign M_bubble_o = m_exc || w_exc;
    assign W_stall_o  = w_exc;
    assign set_cc_o   = (e_q.icode == I_OPQ) && !m_exc && !w_exc;

    always_comb begin
        e_d = E_BUBBLE;
        if (!e_bubble) begin
            e_d.stat  = de_if.D_stat;
            e_d.icode = de_if.D_icode;
            e_d.ifun  = de_if.D_ifun;
            e_d.valc  = de_if.D_valC;
            e_d.vala  = de_if.d_valA;
            e_d.valb  = de_if.d_valB;
            e_d.dste  = de_if.d_dstE;
            e_d.dstm  = de_if.d_dstM;
            e_d.srca  = de_if.d_srcA;
            e_d.srcb  = de_if.d_srcB;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            e_q <= E_BUBBLE;
        end else begin
            e_q <= e_d;
        end
    end

    assign de_if.E_stat  = e_q.stat;
    assign de_if.E_icode = e_q.icode;
    assign de_if.E_ifun  = e_q.ifun;
    assign de_if.E_valC  = e_q.valc;
    assign de_if.E_valA  = e_q.vala;
    assign de_if.E_valB  = e_q.valb;
    assign de_if.E_dstE  = e_q.dste;
    assign de_if.E_dstM  = e_q.dstm;
    assign de_if.E_srcA  = e_q.srca;
    assign de_if.E_srcB  = e_q.srcb;
endmodule

// File: tb/tb_e_pipe_ctrl.sv
// tb/tb_e_pipe_ctrl.sv - table-driven bench for the E register and hazard controls
module tb_e_pipe_ctrl;
    logic       clk;
    logic       rst;
    logic [3:0] m_icode;
    logic       cnd;
    logic [2:0] m_stat;
    logic [2:0] w_stat;
    logic       f_stall, d_stall, d_bubble, m_bubble, w_stall, set_cc;

    int n_pass  = 0;
    int n_total = 0;

    e_pipe_ctrl_if #(.DATA_W(64), .REG_W(4), .STAT_W(3)) bus ();

    e_pipe_ctrl #(.DATA_W(64), .REG_W(4), .STAT_W(3)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .de_if      (bus),
        .M_icode_i  (m_icode),
        .e_Cnd_i    (cnd),
        .m_stat_i   (m_stat),
        .W_stat_i   (w_stat),
        .F_stall_o  (f_stall),
        .D_stall_o  (d_stall),
        .D_bubble_o (d_bubble),
        .M_bubble_o (m_bubble),
        .W_stall_o  (w_stall),
        .set_cc_o   (set_cc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [2:0]  stat;
        logic [3:0]  icode, ifun;
        logic [63:0] valc, vala, valb;
        logic [3:0]  dste, dstm, srca, srcb;
        logic [3:0]  m_icode;
        logic        cnd;
        logic [2:0]  m_stat, w_stat;
        logic        chk;
        logic [5:0]  ctl;
        logic        bub;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(
        input logic r, input logic [2:0] st, input logic [3:0] ic, input logic [3:0] fn,
        input logic [63:0] vc, input logic [63:0] va, input logic [63:0] vb,
        input logic [3:0] de, input logic [3:0] dm, input logic [3:0] sa, input logic [3:0] sb,
        input logic [3:0] mi, input logic c, input logic [2:0] ms, input logic [2:0] ws,
        input logic ck, input logic [5:0] ctl, input logic bub);
        vec_t t;
        t.rst = r; t.stat = st; t.icode = ic; t.ifun = fn;
        t.valc = vc; t.vala = va; t.valb = vb;
        t.dste = de; t.dstm = dm; t.srca = sa; t.srcb = sb;
        t.m_icode = mi; t.cnd = c; t.m_stat = ms; t.w_stat = ws;
        t.chk = ck; t.ctl = ctl; t.bub = bub;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input vec_t t);
        rst          = t.rst;
        bus.D_stat   = t.stat;
        bus.D_icode  = t.icode;
        bus.D_ifun   = t.ifun;
        bus.D_valC   = t.valc;
        bus.d_valA   = t.vala;
        bus.d_valB   = t.valb;
        bus.d_dstE   = t.dste;
        bus.d_dstM   = t.dstm;
        bus.d_srcA   = t.srca;
        bus.d_srcB   = t.srcb;
        m_icode      = t.m_icode;
        cnd          = t.cnd;
        m_stat       = t.m_stat;
        w_stat       = t.w_stat;
    endtask

    task automatic check_e(input string tag, input vec_t t);
        if (t.bub) begin
            chk({tag, " E_stat"},  64'(bus.E_stat),  64'h1);
            chk({tag, " E_icode"}, 64'(bus.E_icode), 64'h1);
            chk({tag, " E_ifun"},  64'(bus.E_ifun),  64'h0);
            chk({tag, " E_valC"},  bus.E_valC,       64'h0);
            chk({tag, " E_valA"},  bus.E_valA,       64'h0);
            chk({tag, " E_valB"},  bus.E_valB,       64'h0);
            chk({tag, " E_dstE"},  64'(bus.E_dstE),  64'hF);
            chk({tag, " E_dstM"},  64'(bus.E_dstM),  64'hF);
            chk({tag, " E_srcA"},  64'(bus.E_srcA),  64'hF);
            chk({tag, " E_srcB"},  64'(bus.E_srcB),  64'hF);
        end else begin
            chk({tag, " E_stat"},  64'(bus.E_stat),  64'(t.stat));
            chk({tag, " E_icode"}, 64'(bus.E_icode), 64'(t.icode));
            chk({tag, " E_ifun"},  64'(bus.E_ifun),  64'(t.ifun));
            chk({tag, " E_valC"},  bus.E_valC,       t.valc);
            chk({tag, " E_valA"},  bus.E_valA,       t.vala);
            chk({tag, " E_valB"},  bus.E_valB,       t.valb);
            chk({tag, " E_dstE"},  64'(bus.E_dstE),  64'(t.dste));
            chk({tag, " E_dstM"},  64'(bus.E_dstM),  64'(t.dstm));
            chk({tag, " E_srcA"},  64'(bus.E_srcA),  64'(t.srca));
            chk({tag, " E_srcB"},  64'(bus.E_srcB),  64'(t.srcb));
        end
    endtask

    task automatic apply(input int idx, input vec_t t);
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        drive(t);
        #1;
        if (t.chk) begin
            chk({tag, " F_stall"},  64'(f_stall),  64'(t.ctl[5]));
            chk({tag, " D_stall"},  64'(d_stall),  64'(t.ctl[4]));
            chk({tag, " D_bubble"}, 64'(d_bubble), 64'(t.ctl[3]));
            chk({tag, " M_bubble"}, 64'(m_bubble), 64'(t.ctl[2]));
            chk({tag, " W_stall"},  64'(w_stall),  64'(t.ctl[1]));
            chk({tag, " set_cc"},   64'(set_cc),   64'(t.ctl[0]));
            chk({tag, " stall_and_bubble"}, 64'(d_stall & d_bubble), 64'h0);
        end
        @(posedge clk);
        #1;
        check_e(tag, t);
    endtask

    initial begin
        vec_t h;
        // rst stat ic fn valC valA valB dstE dstM srcA srcB | M_icode cnd m_stat W_stat | chk ctl{F_stall,D_stall,D_bubble,M_bubble,W_stall,set_cc} bub
        tv.push_back(mk(1, 1, 6, 0, 64'h11, 5, 7, 3, 4'hF, 1, 2,           1, 0, 1, 1, 0, 6'b000000, 1));
        tv.push_back(mk(0, 1, 6, 0, 0, 5, 7, 3, 4'hF, 1, 2,                1, 0, 1, 1, 1, 6'b000000, 0));
        tv.push_back(mk(0, 1, 5, 0, 16, 0, 9, 4'hF, 2, 4'hF, 4,            1, 0, 1, 1, 1, 6'b000001, 0));
        tv.push_back(mk(0, 1, 6, 1, 0, 3, 4, 2, 4'hF, 2, 3,                1, 0, 1, 1, 1, 6'b110000, 1));
        tv.push_back(mk(0, 1, 5, 0, 8, 0, 9, 4'hF, 2, 4'hF, 5,             1, 0, 1, 1, 1, 6'b000000, 0));
        tv.push_back(mk(0, 1, 6, 0, 0, 1, 2, 6, 4'hF, 4'hF, 4'hF,          1, 0, 1, 1, 1, 6'b000000, 0));
        tv.push_back(mk(0, 1, 5, 0, 24, 0, 3, 4'hF, 4'hF, 4'hF, 3,         1, 0, 1, 1, 1, 6'b000001, 0));
        tv.push_back(mk(0, 1, 6, 0, 0, 6, 6, 6, 4'hF, 4'hF, 4'hF,          1, 0, 1, 1, 1, 6'b000000, 0));
        tv.push_back(mk(0, 1, 4'hB, 0, 0, 64'h100, 64'h100, 4, 7, 4, 4,    1, 0, 1, 1, 1, 6'b000001, 0));
        tv.push_back(mk(0, 1, 6, 2, 0, 1, 2, 7, 4'hF, 1, 7,                1, 0, 1, 1, 1, 6'b110000, 1));
        tv.push_back(mk(0, 1, 7, 1, 100, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF,     1, 0, 1, 1, 1, 6'b000000, 0));
        tv.push_back(mk(0, 1, 6, 0, 0, 9, 3, 9, 4'hF, 8, 9,                1, 0, 1, 1, 1, 6'b001000, 1));
        tv.push_back(mk(0, 1, 7, 2, 200, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF,     1, 0, 1, 1, 1, 6'b000000, 0));
        tv.push_back(mk(0, 1, 3, 0, 42, 0, 0, 5, 4'hF, 4'hF, 4'hF,         1, 1, 1, 1, 1, 6'b000000, 0));
        tv.push_back(mk(0, 1, 9, 0, 0, 64'h200, 64'h200, 4, 4'hF, 4, 4,    1, 1, 1, 1, 1, 6'b101000, 0));
        tv.push_back(mk(0, 1, 5, 0, 8, 0, 6, 4'hF, 4, 4'hF, 6,             1, 1, 1, 1, 1, 6'b101000, 0));
        tv.push_back(mk(0, 1, 9, 0, 0, 64'h300, 64'h300, 4, 4'hF, 4, 4,    1, 1, 1, 1, 1, 6'b110000, 1));
        tv.push_back(mk(0, 1, 6, 0, 0, 1, 2, 1, 4'hF, 1, 2,                9, 1, 1, 1, 1, 6'b101000, 0));
        tv.push_back(mk(0, 1, 6, 3, 0, 3, 4, 2, 4'hF, 3, 4,                1, 1, 3, 1, 1, 6'b000100, 0));
        tv.push_back(mk(0, 1, 1, 0, 0, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF,       1, 1, 1, 2, 1, 6'b000110, 0));
        tv.push_back(mk(0, 1, 7, 3, 300, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF,     1, 1, 4, 1, 1, 6'b000100, 0));
        tv.push_back(mk(1, 1, 6, 0, 0, 77, 1, 3, 4'hF, 1, 2,               1, 0, 1, 1, 1, 6'b001000, 1));
        tv.push_back(mk(1, 1, 6, 0, 0, 88, 1, 3, 4'hF, 1, 2,               1, 1, 1, 1, 1, 6'b000000, 1));
        tv.push_back(mk(0, 3, 6, 4, 5, 64'hDEAD, 64'hBEEF, 8, 4'hF, 1, 2,  1, 1, 1, 1, 1, 6'b000000, 0));
        tv.push_back(mk(0, 4, 2, 0, 0, 12, 0, 5, 4'hF, 3, 4'hF,            1, 1, 1, 1, 1, 6'b000001, 0));

        for (int i = 0; i < tv.size(); i++) apply(i, tv[i]);

        // Reset held across several edges with live inputs, then released.
        h = mk(1, 2, 6, 5, 64'hAA, 64'hBB, 64'hCC, 1, 2, 3, 4, 1, 1, 1, 1, 0, 6'b000000, 1);
        for (int k = 0; k < 3; k++) apply(100 + k, h);
        h.rst = 0;
        h.chk = 1;
        h.bub = 0;
        apply(103, h);

        // Back-to-back load/use on consecutive MRMOVQs with both exceptions active.
        apply(110, mk(0, 1, 5, 0, 0, 0, 1, 4'hF, 3, 4'hF, 1, 1, 1, 3, 3, 1, 6'b000110, 0));
        apply(111, mk(0, 1, 5, 0, 0, 0, 3, 4'hF, 5, 4'hF, 3, 1, 1, 3, 3, 1, 6'b110110, 1));
        apply(112, mk(0, 1, 6, 0, 0, 5, 6, 1, 4'hF, 5, 6, 1, 1, 1, 1, 1, 6'b000000, 0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/e_pipe_ctrl.md
Name: e_pipe_ctrl

Overview:
- Decode-to-execute pipeline register (E register) plus the pipeline hazard-control logic for the 5-stage Y86-64 core.
- Captures the decode-stage fields each cycle, including the forwarded d_valA/d_valB produced by decode.
- Inserts bubbles on load/use hazards and mispredicted branches.
- Drives the stall/bubble controls for the F, D, M and W registers and the condition-code write enable.

Parameters:
- DATA_W, 64, width of data/value buses
- REG_W, 4, register-ID width; RNONE = all ones (4'hF)
- STAT_W, 3, status width; AOK=1, HLT=2, ADR=3, INS=4

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous active-high reset
- D_stat_i  in  STAT_W  status of instruction in D
- D_icode_i  in  4  icode in D
- D_ifun_i  in  4  ifun in D
- D_valC_i  in  DATA_W  constant word in D
- d_valA_i  in  DATA_W  forwarded valA from decode
- d_valB_i  in  DATA_W  forwarded valB from decode
- d_dstE_i  in  REG_W  decode dstE
- d_dstM_i  in  REG_W  decode dstM
- d_srcA_i  in  REG_W  decode srcA
- d_srcB_i  in  REG_W  decode srcB
- M_icode_i  in  4  icode in M register
- e_Cnd_i  in  1  branch/cmov condition from execute
- m_stat_i  in  STAT_W  memory-stage status
- W_stat_i  in  STAT_W  write-back status
- E_stat_o, E_icode_o, E_ifun_o  out  STAT_W/4/4  registered fields
- E_valC_o, E_valA_o, E_valB_o  out  DATA_W  registered values
- E_dstE_o, E_dstM_o, E_srcA_o, E_srcB_o  out  REG_W  registered register IDs
- F_stall_o, D_stall_o, D_bubble_o, M_bubble_o, W_stall_o  out  1  combinational pipe controls
- set_cc_o  out  1  combinational CC write enable for execute

Behaviour:
- Icodes: HALT=0, NOP=1, RRMOVQ=2, IRMOVQ=3, RMMOVQ=4, MRMOVQ=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSHQ=A, POPQ=B.
- Bubble value: stat=AOK, icode=NOP, ifun=0, valC/valA/valB=0, dstE/dstM/srcA/srcB=RNONE.
- Reset: rst_i high at a clock edge loads the bubble value into all E outputs. Reset overrides everything else.
- Internal signals (combinational, from current E outputs and inputs):
  - load_use = (E_icode in {MRMOVQ,POPQ}) && E_dstM!=RNONE && (E_dstM==d_srcA_i || E_dstM==d_srcB_i)
  - mispredict = E_icode==JXX && !e_Cnd_i
  - ret_in_pipe = RET in {D_icode_i, E_icode, M_icode_i}
  - exc(s) = s in {ADR,INS,HLT}
- Output equations:
  - E_bubble (internal) = mispredict || load_use
  - F_stall_o = load_use || ret_in_pipe
  - D_stall_o = load_use
  - D_bubble_o = mispredict || (!load_use && ret_in_pipe)
  - M_bubble_o = exc(m_stat_i) || exc(W_stat_i)
  - W_stall_o = exc(W_stat_i)
  - set_cc_o = E_icode==OPQ && !exc(m_stat_i) && !exc(W_stat_i)
- Clock edge (not reset):
  - E_bubble high: load the bubble value.
  - Otherwise: load all D/d inputs.
  - The E register never stalls.
- Latency: 1 cycle D->E. Controls are valid in the same cycle as their inputs.
- Simultaneous events:
  - mispredict and load_use both true: E bubbles.
  - D_stall_o and D_bubble_o are never both 1 (load_use masks the ret bubble, and load_use cannot coexist with mispredict since E holds one icode).
- No RNONE match: srcA/srcB==RNONE never triggers load_use, even if E_dstM==RNONE.

Test Plan:
- Reset: assert rst_i with arbitrary inputs -> next cycle E_icode=1, E_stat=1, all E reg IDs=F, values 0, set_cc_o=0.
- Passthrough: D_icode=6, ifun=0, d_valA=5, d_valB=7, dstE=3 -> next cycle E_icode=6, E_valA=5, E_valB=7, E_dstE=3; set_cc_o=1 with m_stat=W_stat=AOK.
- Load/use: E holds MRMOVQ with E_dstM=2, d_srcA=2 -> F_stall=1, D_stall=1, D_bubble=0; next cycle E_icode=1. Repeat with d_srcA=d_srcB=F -> no stall.
- Mispredict: E_icode=7, e_Cnd=0 -> D_bubble=1; next cycle E bubble. Same with e_Cnd=1 -> no bubble, D fields captured.
- Ret: D_icode=9 -> F_stall=1, D_bubble=1. Combine with a load/use hazard -> D_stall=1, D_bubble=0.
- Exceptions: m_stat=3 with E_icode=6 -> M_bubble=1, set_cc_o=0. W_stat=2 -> W_stall=1, M_bubble=1. Assert rst_i during a bubble cycle -> reset value loaded.
